song_sequencer: RTL and testbench

//  Steps through the song's note chart ROM at a fixed tempo and presents each chord as exp_notes
//  for a fixed hit window, followed by a silent gap. Consumes per-note hit/miss judgements from

---
 rtl/song_sequencer_pkg.sv | 22 ++
 rtl/song_sequencer_score_keeper.sv | 43 ++++
 rtl/song_sequencer.sv | 148 ++++++++++++++
 tb/tb_song_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: state encodings,
// chart ROM field positions and a small parameter helper.
package song_sequencer_pkg;

  localparam int END_BIT   = 5;
  localparam int NOTES_MSB = 4;
  localparam int NOTE_W    = 5;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_FETCH = 6'b000010,
    S_LATCH = 6'b000100,
    S_ON    = 6'b001000,
    S_OFF   = 6'b010000,
    S_DONE  = 6'b100000
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/song_sequencer_score_keeper.sv
// Score and streak accumulator fed by gameplay judgements,
// saturating both counters; clear restarts a song's tally.
module score_keeper #(
  parameter int MULT_STREAK = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic        judge_valid,
  input  logic        judge_hit,
  output logic [15:0] score,
  output logic [7:0]  streak
);

  logic [1:0]  inc;
  logic [16:0] sum;

  // Multiplier test looks at the streak before this hit
  always_comb begin
    inc = (streak >= 8'(MULT_STREAK)) ? 2'd2 : 2'd1;
    sum = {1'b0, score} + {15'd0, inc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score  <= '0;
      streak <= '0;
    end else if (clear) begin
      score  <= '0;
      streak <= '0;
    end else if (enable && judge_valid) begin
      if (judge_hit) begin
        score  <= sum[16] ? 16'hFFFF : sum[15:0];
        streak <= (streak == 8'hFF) ? streak
                                    : streak + 8'd1;
      end else begin
        streak <= '0;
      end
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Chart sequencer: fetches one chord per entry, holds it for a
// hit window, then a silent gap; tracks score via score_keeper.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int SONG_LEN      = 200,
  parameter int WINDOW_CYCLES = 6250000,
  parameter int GAP_CYCLES    = 6250000,
  parameter int MULT_STREAK   = 10
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [5:0]        rom_data,
  output logic [NOTE_W-1:0] exp_notes,
  input  logic              judge_valid,
  input  logic              judge_hit,
  output logic [15:0]       score,
  output logic [7:0]        streak,
  output logic              busy,
  output logic              song_done
);

  localparam int MAX_CYC = max2(WINDOW_CYCLES, GAP_CYCLES);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] WIN_LAST =
    CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(SONG_LEN - 1);

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [NOTE_W-1:0] exp_d;
  logic              busy_d, done_d;
  logic              clear, enable;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = rom_addr;
    note_d  = note_q;
    exp_d   = exp_notes;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        exp_d = '0;
        if (start) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        if (rom_data[END_BIT]) begin
          state_d = S_DONE;
          exp_d   = '0;
        end else begin
          note_d  = rom_data[NOTES_MSB:0];
          exp_d   = rom_data[NOTES_MSB:0];
          cnt_d   = '0;
          state_d = S_ON;
        end
      end
      S_ON: begin
        if (!pause) begin
          if (cnt_q == WIN_LAST) begin
            state_d = S_OFF;
            cnt_d   = '0;
            exp_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            exp_d = note_q;
          end
        end
      end
      S_OFF: begin
        exp_d = '0;
        if (!pause) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            if (rom_addr == LAST_ADDR) begin
              state_d = S_DONE;
            end else begin
              addr_d  = rom_addr + 1'b1;
              state_d = S_FETCH;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        exp_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    clear  = start &&
             ((state_q == S_IDLE) || (state_q == S_DONE));
    enable = (state_q != S_IDLE);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      note_q    <= '0;
      rom_addr  <= '0;
      exp_notes <= '0;
      busy      <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      note_q    <= note_d;
      rom_addr  <= addr_d;
      exp_notes <= exp_d;
      busy      <= busy_d;
      song_done <= done_d;
    end
  end

  score_keeper #(
    .MULT_STREAK(MULT_STREAK)
  ) u_score (
    .clk        (CLOCK_50),
    .rst        (reset),
    .clear      (clear),
    .enable     (enable),
    .judge_valid(judge_valid),
    .judge_hit  (judge_hit),
    .score      (score),
    .streak     (streak)
  );

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: entry-offset reference model checked
// every cycle, plus directed literal checks on each scenario.
module tb_song_sequencer;

  localparam int ADDR_W  = 8;
  localparam int SLEN    = 4;
  localparam int WIN     = 4;
  localparam int GAP     = 2;
  localparam int MULT    = 2;
  localparam int PERIOD  = WIN + GAP + 2;

  localparam int M_IDLE = 0;
  localparam int M_ACT  = 1;
  localparam int M_DONE = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              pause;
  logic [ADDR_W-1:0] rom_addr;
  logic [5:0]        rom_data = '0;
  logic [4:0]        exp_notes;
  logic              judge_valid;
  logic              judge_hit;
  logic [15:0]       score;
  logic [7:0]        streak;
  logic              busy;
  logic              song_done;

  logic [5:0] rom [0:255];

  int passed = 0;
  int total  = 0;
  logic chk_on = 1'b0;

  int m_mode, m_idx, m_off, m_score, m_streak;

  song_sequencer #(
    .ADDR_W       (ADDR_W),
    .SONG_LEN     (SLEN),
    .WINDOW_CYCLES(WIN),
    .GAP_CYCLES   (GAP),
    .MULT_STREAK  (MULT)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (rst),
    .start      (start),
    .pause      (pause),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .exp_notes  (exp_notes),
    .judge_valid(judge_valid),
    .judge_hit  (judge_hit),
    .score      (score),
    .streak     (streak),
    .busy       (busy),
    .song_done  (song_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name,
                     input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
  endtask

  // Reference model: position within an entry of PERIOD steps
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode   <= M_IDLE;
      m_idx    <= 0;
      m_off    <= 0;
      m_score  <= 0;
      m_streak <= 0;
    end else begin
      if (m_mode != M_ACT && start) begin
        m_score  <= 0;
        m_streak <= 0;
      end else if (m_mode != M_IDLE && judge_valid) begin
        if (judge_hit) begin
          m_score <= (m_score + (m_streak >= MULT ? 2 : 1)
                      > 65535) ? 65535
                   : m_score + (m_streak >= MULT ? 2 : 1);
          m_streak <= (m_streak == 255) ? 255 : m_streak + 1;
        end else begin
          m_streak <= 0;
        end
      end
      if (m_mode != M_ACT) begin
        if (start) begin
          m_mode <= M_ACT;
          m_idx  <= 0;
          m_off  <= 0;
        end
      end else if (!(pause && m_off >= 2)) begin
        if (m_off == 1 && rom[m_idx][5]) begin
          m_mode <= M_DONE;
        end else if (m_off == PERIOD - 1) begin
          if (m_idx == SLEN - 1) m_mode <= M_DONE;
          else begin
            m_idx <= m_idx + 1;
            m_off <= 0;
          end
        end else begin
          m_off <= m_off + 1;
        end
      end
    end
  end

  function automatic int model_exp();
    if (m_mode == M_ACT && m_off >= 2 && m_off < 2 + WIN)
      return int'(rom[m_idx][4:0]);
    return 0;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("rom_addr", int'(rom_addr), m_idx);
      chk("exp_notes", int'(exp_notes), model_exp());
      chk("score", int'(score), m_score);
      chk("streak", int'(streak), m_streak);
      chk("busy", int'(busy), int'(m_mode == M_ACT));
      chk("song_done", int'(song_done),
          int'(m_mode == M_DONE));
    end
  end

  task automatic judge(input logic hit);
    judge_valid = 1'b1;
    judge_hit   = hit;
    @(negedge clk);
    judge_valid = 1'b0;
  endtask

  task automatic load_rom(input logic [5:0] a, b, c, d);
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = a;
    rom[1] = b;
    rom[2] = c;
    rom[3] = d;
  endtask

  // Pulse start, then run until song_done; n counts cycles
  task automatic run_song(output int n, output int rises,
                          output int wraps);
    logic [4:0] prev;
    logic seen_nz;
    prev = '0;
    seen_nz = 1'b0;
    n = 0;
    rises = 0;
    wraps = 0;
    start = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (exp_notes != 0 && prev == 0) rises++;
      prev = exp_notes;
      if (rom_addr != 0) seen_nz = 1'b1;
      else if (seen_nz) wraps++;
    end while (!song_done && n < 200);
    chk("song_ends", int'(song_done), 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!song_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", int'(song_done), 1);
  endtask

  task automatic wait_on(input int bound);
    int n;
    n = 0;
    while (exp_notes == 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("reach_on", int'(exp_notes != 0), 1);
  endtask

  initial begin
    int n, rises, wraps, on_len;
    int first01, first06, cnt01, cnt06;
    logic [4:0] q[$];

    rst = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    judge_valid = 1'b0;
    judge_hit = 1'b0;
    load_rom(6'h01, 6'h06, 6'h00, 6'h3F);
    #1 rst = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_exp", int'(exp_notes), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(song_done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Chord, chord, rest, end flag
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      q.push_back(exp_notes);
    end while (!song_done && n < 200);
    first01 = -1;
    first06 = -1;
    cnt01 = 0;
    cnt06 = 0;
    foreach (q[i]) begin
      if (q[i] == 5'h01) begin
        cnt01++;
        if (first01 < 0) first01 = i;
      end
      if (q[i] == 5'h06) begin
        cnt06++;
        if (first06 < 0) first06 = i;
      end
    end
    chk("t1_cycles", n, 27);
    chk("t1_on01", cnt01, WIN);
    chk("t1_on06", cnt06, WIN);
    chk("t1_period", first06 - first01, 8);
    chk("t1_done", int'(song_done), 1);
    chk("t1_busy", int'(busy), 0);

    // Three hits then a miss
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    judge(1'b1);
    chk("t2_s1", int'(score), 1);
    chk("t2_k1", int'(streak), 1);
    judge(1'b1);
    chk("t2_s2", int'(score), 2);
    chk("t2_k2", int'(streak), 2);
    judge(1'b1);
    chk("t2_s3", int'(score), 4);
    chk("t2_k3", int'(streak), 3);
    judge(1'b0);
    chk("t2_s4", int'(score), 4);
    chk("t2_k4", int'(streak), 0);
    wait_done();

    // Pause for 10 cycles inside the first window
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_on(20);
    on_len = 1;
    @(negedge clk);
    if (exp_notes == 5'h01) on_len++;
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      judge_valid = (i == 0);
      judge_hit = 1'b1;
      @(negedge clk);
      if (exp_notes == 5'h01) on_len++;
    end
    judge_valid = 1'b0;
    pause = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exp_notes != 5'h01) break;
      on_len++;
    end
    chk("t3_on_len", on_len, 14);
    chk("t3_score", int'(score), 1);
    wait_done();

    // No end flag: all four entries, then stop
    load_rom(6'h01, 6'h02, 6'h04, 6'h08);
    run_song(n, rises, wraps);
    chk("t4_cycles", n, 33);
    chk("t4_entries", rises, 4);
    chk("t4_nowrap", wraps, 0);
    chk("t4_addr", int'(rom_addr), 3);

    // Build score 5, ignored start, reset mid-window
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    judge(1'b1);
    judge(1'b1);
    judge(1'b1);
    judge(1'b0);
    judge(1'b1);
    chk("t5_score", int'(score), 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_busy", int'(busy), 1);
    wait_on(20);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_addr", int'(rom_addr), 0);
    chk("t5_exp", int'(exp_notes), 0);
    chk("t5_score0", int'(score), 0);
    chk("t5_streak", int'(streak), 0);
    chk("t5_busy0", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // Long string of hits while paused in a window
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_on(20);
    pause = 1'b1;
    judge_valid = 1'b1;
    judge_hit = 1'b1;
    repeat (33000) @(negedge clk);
    judge_valid = 1'b0;
    chk("t6_score", int'(score), 65535);
    chk("t6_streak", int'(streak), 255);
    pause = 1'b0;
    wait_done();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
